// File: rtl/arith_pkg.sv
// Shared types and elaboration helpers for the sequential subtractor family.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    function automatic int ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // A single-digit configuration still needs a 1-bit counter.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit digit_cfg_ok(input int width, input int digit);
        return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/fs_digit.sv
// Combinational DIGIT-bit ripple subtractor: {bo, d} = a - b - bi.
module fs_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bi,
    output logic [DIGIT-1:0] d,
    output logic             bo
);

    logic [DIGIT:0] br;

    always_comb begin
        br    = '0;
        d     = '0;
        br[0] = bi;
        for (int i = 0; i < DIGIT; i++) begin
            d[i]    = a[i] ^ b[i] ^ br[i];
            br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
        end
        bo = br[DIGIT];
    end

endmodule

// File: rtl/seq_sub.sv
// Multi-cycle subtractor, DIGIT bits per clock, LSB digit first, start/busy/done handshake.
// Define SEQ_SUB_SAT_EN to clamp diff to zero on unsigned underflow.
module seq_sub
    import arith_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int NDIG  = ndig(WIDTH, DIGIT);
    localparam int CNT_W = cnt_w(NDIG);

    generate
        if (!digit_cfg_ok(WIDTH, DIGIT)) begin : g_bad_cfg
            $error("seq_sub: WIDTH must be a non-zero multiple of DIGIT");
        end
    endgenerate

    sub_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             borrow_q;
    logic             busy_q;
    logic             done_q;
    logic             bout_q;
    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT-1:0] d_dig;
    logic             borrow_d;
    logic             accept;
    logic             last;

    assign accept = start && (state_q != RUN);
    assign last   = (cnt_q == CNT_W'(NDIG - 1));
    assign a_dig  = a_q[cnt_q*DIGIT +: DIGIT];
    assign b_dig  = b_q[cnt_q*DIGIT +: DIGIT];

    fs_digit #(.DIGIT(DIGIT)) u_digit (
        .a  (a_dig),
        .b  (b_dig),
        .bi (borrow_q),
        .d  (d_dig),
        .bo (borrow_d)
    );

    always_comb begin
        res_d = res_q;
        res_d[cnt_q*DIGIT +: DIGIT] = d_dig;
    end

    // Operand and partial-result storage carries no reset; it is always rewritten before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= b;
        end
        if (state_q == RUN) begin
            res_q <= res_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bout_q   <= 1'b0;
            diff_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q  <= RUN;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        borrow_q <= bin;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                RUN: begin
                    borrow_q <= borrow_d;
                    cnt_q    <= last ? '0 : cnt_q + 1'b1;
                    if (last) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        bout_q  <= borrow_d;
`ifdef SEQ_SUB_SAT_EN
                        diff_q  <= borrow_d ? '0 : res_d;
`else
                        diff_q  <= res_d;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: doc/seq_sub.md
# seq_sub

Parametrised multi-cycle subtractor computing `diff = a - b - bin` over WIDTH bits, DIGIT bits per clock, LSB digit first, with a registered borrow chain between digits. It is the sequential successor to the single-bit full subtractor in the arithmetic library. It sits between an operand-issuing controller and a result consumer, using a start/busy/done handshake.

## Interface
- `WIDTH`, 16, operand and result width; must be a multiple of DIGIT.
- `DIGIT`, 4, bits processed per cycle, 1..WIDTH; NDIG = WIDTH/DIGIT.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `a`  in  WIDTH  minuend; captured on an accepted start.
- `b`  in  WIDTH  subtrahend; captured on an accepted start.
- `bin`  in  1  borrow-in to digit 0; captured on an accepted start.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when the result becomes valid.
- `diff`  out  WIDTH  result; held stable from `done` until the next accepted start.
- `bout`  out  1  borrow out of the MSB (unsigned underflow flag).

## Operation
- States and transitions:
  - IDLE: on `start`, go to RUN.
  - RUN: stays for exactly NDIG cycles, then goes to DONE.
  - DONE: on `start`, go to RUN; otherwise go to IDLE.
- Accepted start: captures `a`, `b` and `bin`, clears the digit counter, and loads the borrow register with `bin`. `start` during RUN is ignored, with no queuing.
- Each RUN cycle:
  - The digit slice computes `{borrow_next, d} = a_dig - b_dig - borrow` for digit index cnt.
  - d is written to bits `[cnt*DIGIT +: DIGIT]` of the result register, and the borrow register takes `borrow_next`.
- Per-bit borrow rule: `Bo = (~A & B) | (~(A ^ B) & Bi)`; difference bit = `A ^ B ^ Bi`.
- After the last digit (cnt == NDIG-1): `bout` takes the final borrow, `diff` is updated from the result register, and `done` is set.
- `diff` and `bout` change only at the DONE transition. They stay at their last value through IDLE and through a subsequent RUN.
- Reset values: `busy`=0, `done`=0, `diff`=0, `bout`=0, state=IDLE, counter=0, borrow=0.
- Reset mid-operation: the operation is aborted and all outputs return to their reset values immediately (asynchronously). `done` is not produced for the aborted operation.

## Timing
- If start is accepted at edge k: `busy` is high from after edge k until after edge k+NDIG.
- `done` is high for the single cycle between edges k+NDIG and k+NDIG+1; `diff` and `bout` are valid from edge k+NDIG.
- Latency is NDIG cycles from the start edge to `done`.
- Back-to-back operation: start asserted during DONE is accepted, giving throughput of one result per NDIG+1 cycles.
- DIGIT=WIDTH: NDIG=1, so `done` follows one cycle after start.
- The counter width is `$clog2(NDIG)`, with a minimum of 1.

## Configuration
- `SEQ_SUB_SAT_EN` defined: when the final borrow is 1, `diff` is forced to 0 (unsigned saturation) and `bout` still reports 1.
- `SEQ_SUB_SAT_EN` undefined: `diff` is the raw modulo-2^WIDTH result.

## Structure
- Package `arith_pkg` holds:
  - the state enum `sub_state_t` (IDLE, RUN, DONE);
  - the localparam function for NDIG;
  - the elaboration check WIDTH % DIGIT == 0.
- Sub-module `fs_digit`: a combinational DIGIT-bit ripple subtractor built from the per-bit rule, with ports a, b, bi, d, bo. It is instantiated once in `seq_sub`.

## Test plan
- WIDTH=16, DIGIT=4: a=0x1234, b=0x0234, bin=0 → `done` 4 cycles after start, `diff`=0x1000, `bout`=0.
- a=0x0000, b=0x0001, bin=0 → `diff`=0xFFFF, `bout`=1. With `SEQ_SUB_SAT_EN` → `diff`=0x0000, `bout`=1.
- a=0x8000, b=0x7FFF, bin=1 → `diff`=0x0000, `bout`=0. This exercises the borrow crossing every digit boundary.
- Start at cycle 0, then `start` pulsed again at cycle 2 with different operands → ignored. One `done` at cycle 4 with the first result; `diff` stays unchanged until the next accepted start.
- `rst_n` low at cycle 2 of RUN → `busy`, `done`, `diff` and `bout` are all 0 immediately. No `done` follows, and a new start after release completes normally.
- Random operands across DIGIT ∈ {1, 4, 16} and WIDTH=16, including back-to-back starts during DONE → every result matches `(a - b - bin) mod 2^16` and borrow, with `done` spacing NDIG+1.
